// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI4-Lite response codes, FSM encoding and default widths
package axil_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } state_e;

endpackage

// File: rtl/axil_rsp_slot.sv
// rtl/axil_rsp_slot.sv - single-entry response register with valid/ready
module axil_rsp_slot
    import axil_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic              load_we,
    input  logic [DATA_W-1:0] load_rdata,
    input  logic [1:0]        load_resp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_we,
    output logic [DATA_W-1:0] out_rdata,
    output logic [1:0]        out_resp
);

    logic              valid_q, valid_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        resp_q, resp_d;

    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        resp_d  = resp_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            we_d    = load_we;
            rdata_d = load_rdata;
            resp_d  = load_resp;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            resp_q  <= RESP_OKAY;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
        end
    end

    assign out_valid = valid_q;
    assign out_we    = we_q;
    assign out_rdata = rdata_q;
    assign out_resp  = resp_q;

endmodule

// File: rtl/axil_master.sv
// rtl/axil_master.sv - single-outstanding command/response to AXI4-Lite initiator (AXIL_MASTER_WSTRB_EN adds byte strobes)
module axil_master
    import axil_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              m_aclk,
    input  logic              m_aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
`ifdef AXIL_MASTER_WSTRB_EN
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    output logic [DATA_W-1:0] m_axi_wdata,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    input  logic [1:0]        m_axi_bresp,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              slot_load;
    logic [DATA_W-1:0] slot_rdata;
    logic [1:0]        slot_resp;
`ifdef AXIL_MASTER_WSTRB_EN
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
`endif

    // Gated with reset so every output reads 0 while reset is held, even though IDLE is the reset state.
    assign cmd_ready    = (state_q == ST_IDLE) && m_aresetn;
    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = wdata_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        slot_load     = 1'b0;
        slot_rdata    = '0;
        slot_resp     = RESP_OKAY;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
`ifdef AXIL_MASTER_WSTRB_EN
        wstrb_d       = wstrb_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    we_d      = cmd_we;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
`ifdef AXIL_MASTER_WSTRB_EN
                    wstrb_d   = cmd_wstrb;
`endif
                    state_d   = cmd_we ? ST_WR : ST_RD_ADDR;
                end
            end
            ST_WR: begin
                // AW and W retire independently; leave only once both have handshaken.
                m_axi_awvalid = !aw_done_q;
                m_axi_wvalid  = !w_done_q;
                aw_done_d     = aw_done_q || m_axi_awready;
                w_done_d      = w_done_q || m_axi_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    slot_load = 1'b1;
                    slot_resp = m_axi_bresp;
                    state_d   = ST_RSP;
                end
            end
            ST_RD_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    slot_load  = 1'b1;
                    slot_rdata = m_axi_rdata;
                    slot_resp  = m_axi_rresp;
                    state_d    = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_valid && rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge m_aclk) begin
        if (!m_aresetn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef AXIL_MASTER_WSTRB_EN
            wstrb_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
`ifdef AXIL_MASTER_WSTRB_EN
            wstrb_q   <= wstrb_d;
`endif
        end
    end

`ifdef AXIL_MASTER_WSTRB_EN
    assign m_axi_wstrb = wstrb_q;
`endif

    axil_rsp_slot #(
        .DATA_W (DATA_W)
    ) u_rsp_slot (
        .clk        (m_aclk),
        .resetn     (m_aresetn),
        .load       (slot_load),
        .load_we    (we_q),
        .load_rdata (slot_rdata),
        .load_resp  (slot_resp),
        .out_valid  (rsp_valid),
        .out_ready  (rsp_ready),
        .out_we     (rsp_we),
        .out_rdata  (rsp_rdata),
        .out_resp   (rsp_resp)
    );

endmodule
